// File: rtl/hamming_serial_feeder.sv
// Driver for a bit-serial Hamming distance accumulator. It takes in a word pair, clears the
// accumulator, streams the bits LSB first, then captures and returns the distance.
// Optional popcount cross-check of the accumulator result: define SELF_CHECK_EN.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | in_ready high, waiting for a word pair
// CLEAR  | one-cycle acc_clr pulse to the accumulator
// STREAM | N cycles, one garbler/evaluator bit per cycle, LSB first
// HOLD   | res_valid high until the consumer takes res_dist
module hamming_serial_feeder #(
  parameter int N = 16,
  localparam int W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] g_word,
  input  logic [N-1:0] e_word,
  output logic         acc_clr,
  output logic         g_bit,
  output logic         e_bit,
  input  logic [W-1:0] acc_o,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_dist,
  output logic         err
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, HOLD} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [N-1:0]  g_q;
  logic [N-1:0]  e_q;
  logic          accept;
  logic          capture;

  assign accept  = (state == IDLE) && in_valid && in_ready;
  assign capture = (state == STREAM) && (idx == LAST_IDX);

  // in_ready is registered, so it reads low while reset is asserted and for one
  // cycle after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      g_q       <= '0;
      e_q       <= '0;
      in_ready  <= 1'b0;
      acc_clr   <= 1'b0;
      g_bit     <= 1'b0;
      e_bit     <= 1'b0;
      res_valid <= 1'b0;
      res_dist  <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            g_q      <= g_word;
            e_q      <= e_word;
            in_ready <= 1'b0;
            acc_clr  <= 1'b1;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          acc_clr <= 1'b0;
          idx     <= '0;
          g_bit   <= g_q[0];
          e_bit   <= e_q[0];
          state   <= STREAM;
        end
        STREAM: begin
          if (capture) begin
            res_dist  <= acc_o;
            res_valid <= 1'b1;
            g_bit     <= 1'b0;
            e_bit     <= 1'b0;
            state     <= HOLD;
          end else begin
            idx   <= idx + IW'(1);
            g_bit <= g_q[idx + IW'(1)];
            e_bit <= e_q[idx + IW'(1)];
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SELF_CHECK_EN
  function automatic logic [W-1:0] popcount(input logic [N-1:0] x);
    logic [W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + W'(x[i]);
    return c;
  endfunction

  logic [W-1:0] ref_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_q <= '0;
      err   <= 1'b0;
    end else begin
      if (accept) ref_q <= popcount(g_word ^ e_word);
      if (capture && (acc_o != ref_q)) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hamming_serial_feeder.sv
// Self-checking bench for hamming_serial_feeder. It contains a behavioural accumulator model,
// a vector table, hand-written corner sequences and randomized pairs.
module tb_hamming_serial_feeder;

  localparam int N = 16;
  localparam int W = $clog2(N + 1);

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] g_word;
  logic [N-1:0] e_word;
  logic         acc_clr;
  logic         g_bit;
  logic         e_bit;
  logic [W-1:0] acc_o;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_dist;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  hamming_serial_feeder #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .g_word(g_word), .e_word(e_word), .acc_clr(acc_clr), .g_bit(g_bit),
    .e_bit(e_bit), .acc_o(acc_o), .res_valid(res_valid), .res_ready(res_ready),
    .res_dist(res_dist), .err(err)
  );

  // Accumulator model: the sum is cleared by acc_clr and grows by g^e each cycle.
  // acc_o includes the current bit. extra_one injects an accumulator fault.
  logic [W-1:0] acc_sum = '0;
  bit           extra_one = 1'b0;
  always @(posedge clk) begin
    if (acc_clr) acc_sum <= '0;
    else         acc_sum <= acc_sum + W'(g_bit ^ e_bit);
  end
  assign acc_o = acc_sum + W'(g_bit ^ e_bit) + W'(extra_one);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a pair and return in the acc_clr cycle, which is one cycle after acceptance.
  task automatic start_pair(input logic [N-1:0] g, input logic [N-1:0] e);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    g_word   = g;
    e_word   = e;
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) check("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("acc_clr_pulse", {acc_clr, in_ready}, 2'b10);
  endtask

  // Collect the serial stream, then check the result's latency, value and idle bits.
  task automatic stream_and_capture(input logic [N-1:0] g, input logic [N-1:0] e,
                                    input logic [W-1:0] exp_d);
    logic [N-1:0] gs;
    logic [N-1:0] es;
    bit           clr_again = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      gs[k] = g_bit;
      es[k] = e_bit;
      if (acc_clr) clr_again = 1'b1;
    end
    check("g_serial", gs, g);
    check("e_serial", es, e);
    check("acc_clr_once", clr_again, 0);
    check("early_res_valid", res_valid, 0);
    @(negedge clk);
    check("res_valid_latency", res_valid, 1);
    check("res_dist", res_dist, exp_d);
    check("bits_idle_hold", {g_bit, e_bit, in_ready}, 3'b000);
    extra_one = 1'b0;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("consume", {res_valid, in_ready}, 2'b01);
    check("err_flag", err, exp_err);
  endtask

  typedef struct {
    logic [N-1:0] g;
    logic [N-1:0] e;
    logic [W-1:0] d;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] e;

    tbl[0] = '{16'hFFFF, 16'h0000, 5'd16};
    tbl[1] = '{16'hA5A5, 16'hA5A5, 5'd0};
    tbl[2] = '{16'h0001, 16'h0000, 5'd1};
    tbl[3] = '{16'h8000, 16'h0000, 5'd1};
    tbl[4] = '{16'h0F0F, 16'h00FF, 5'd8};
    tbl[5] = '{16'h1234, 16'h4321, 5'd6};

    rst = 1'b0; in_valid = 1'b0; res_ready = 1'b0; g_word = '0; e_word = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {in_ready, acc_clr, g_bit, e_bit, res_valid, res_dist, err}, '0);
    rst = 1'b1;
    @(negedge clk);
    check("after_reset", {in_ready, acc_clr}, 2'b10);

    for (int i = 0; i < 6; i++) begin
      start_pair(tbl[i].g, tbl[i].e);
      stream_and_capture(tbl[i].g, tbl[i].e, tbl[i].d);
      consume();
    end

    // Hold off the result under backpressure for five cycles.
    start_pair(16'h00FF, 16'hFF00);
    stream_and_capture(16'h00FF, 16'hFF00, 5'd16);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("backpressure_hold", {res_valid, in_ready, res_dist}, {1'b1, 1'b0, 5'd16});
    end
    consume();

    // Assert reset while idx is 7. The next pair must see a fresh clear.
    start_pair(16'hFFFF, 16'h0000);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midstream_reset", {res_valid, in_ready, g_bit, e_bit, acc_clr}, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_recover", in_ready, 1);
    start_pair(16'h000F, 16'h0000);
    stream_and_capture(16'h000F, 16'h0000, 5'd4);
    consume();

    // Accumulator fault: it reports one more than the true distance.
    start_pair(16'h0003, 16'h0000);
    extra_one = 1'b1;
`ifdef SELF_CHECK_EN
    exp_err = 1'b1;
`endif
    stream_and_capture(16'h0003, 16'h0000, 5'd3);
    consume();
    start_pair(16'h0003, 16'h0000);
    stream_and_capture(16'h0003, 16'h0000, 5'd2);
    consume();

    for (int i = 0; i < 20; i++) begin
      g = N'($urandom);
      case (i % 5)
        0:       e = g;
        1:       e = ~g;
        default: e = N'($urandom);
      endcase
      res_ready = 1'($urandom);
      start_pair(g, e);
      stream_and_capture(g, e, W'($countones(g ^ e)));
      consume();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
